operand_issue: RTL

//  Decode/operand-fetch stage sitting directly upstream of the 19-bit ALU.

---
 rtl/operand_issue_if.sv | 31 +++
 rtl/operand_issue.sv | 127 ++++++++++++
 2 files changed

// File: rtl/operand_issue_if.sv
// Handshake and bus bundle between the instruction source, the writeback stage and
// the operand_issue stage. The issue stage is the slave; the surrounding pipeline is the master.
interface operand_issue_if #(
   parameter int DATA_W = 19,
   parameter int RA_W   = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] instr;
   logic              wb_en;
   logic [RA_W-1:0]   wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic [4:0]        opcode;
   logic [9:0]        immediate;
   logic [RA_W-1:0]   rd;
   logic              illegal;

   modport master (
      output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, op1, op2, opcode, immediate, rd, illegal
   );

   modport slave (
      input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, op1, op2, opcode, immediate, rd, illegal
   );
endinterface

// File: rtl/operand_issue.sv
// Decode/operand-fetch stage feeding the 19-bit ALU: register file read with writeback
// bypass, busy-bit scoreboard stall, and a one-deep registered output with hold.
module operand_issue #(
   parameter int DATA_W = 19,
   parameter int NREG   = 8,
   parameter int RA_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   operand_issue_if.slave   bus_io
);

   logic [DATA_W-1:0] regfile_q [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;

   logic              out_valid_q;
   logic [DATA_W-1:0] op1_q;
   logic [DATA_W-1:0] op2_q;
   logic [4:0]        opcode_q;
   logic [9:0]        imm_q;
   logic [RA_W-1:0]   rd_q;
   logic              illegal_q;

   logic [4:0]        dec_opcode;
   logic              is_itype;
   logic              is_unary;
   logic              uses_rs2;
   logic [RA_W-1:0]   dec_rd;
   logic [RA_W-1:0]   dec_rs1;
   logic [RA_W-1:0]   dec_rs2;
   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   logic              wb_hit;
   logic              hazard;
   logic              in_ready;
   logic              accept;

   // A writeback landing this cycle releases its register in time for the read.
   function automatic logic is_pending(input logic [NREG-1:0] busy,
                                       input logic [RA_W-1:0] addr,
                                       input logic            hit,
                                       input logic [RA_W-1:0] waddr);
      return busy[addr] && !(hit && (waddr == addr));
   endfunction

   assign dec_opcode = bus_io.instr[18:14];
   assign is_itype   = dec_opcode[4];
   assign dec_rd     = bus_io.instr[13:11];
   assign dec_rs1    = is_itype ? bus_io.instr[13:11] : bus_io.instr[10:8];
   assign dec_rs2    = bus_io.instr[7:5];
   assign is_unary   = (dec_opcode == 5'b00111) || (dec_opcode == 5'b01001) ||
                       (dec_opcode == 5'b01010) || (dec_opcode == 5'b01100) ||
                       (dec_opcode == 5'b01101);
   assign uses_rs2   = !is_itype && !is_unary;
   assign wb_hit     = bus_io.wb_en && (bus_io.wb_addr != '0);

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (dec_rs1 != '0) begin
         rs1_val = (wb_hit && (bus_io.wb_addr == dec_rs1)) ? bus_io.wb_data : regfile_q[dec_rs1];
      end
      if (dec_rs2 != '0) begin
         rs2_val = (wb_hit && (bus_io.wb_addr == dec_rs2)) ? bus_io.wb_data : regfile_q[dec_rs2];
      end
   end

   assign hazard   = is_pending(busy_q, dec_rs1, wb_hit, bus_io.wb_addr) ||
                     is_pending(busy_q, dec_rd, wb_hit, bus_io.wb_addr) ||
                     (uses_rs2 && is_pending(busy_q, dec_rs2, wb_hit, bus_io.wb_addr));
   assign in_ready = (!out_valid_q || bus_io.out_ready) && !hazard;
   assign accept   = bus_io.in_valid && in_ready;

   // Clear from writeback first so a same-register issue in the same cycle wins.
   always_comb begin
      busy_d = busy_q;
      if (wb_hit) begin
         busy_d[bus_io.wb_addr] = 1'b0;
      end
      if (accept && (dec_rd != '0)) begin
         busy_d[dec_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regfile_q[i] <= '0;
         end
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         opcode_q    <= '0;
         imm_q       <= '0;
         rd_q        <= '0;
         illegal_q   <= 1'b0;
      end else begin
         if (wb_hit) begin
            regfile_q[bus_io.wb_addr] <= bus_io.wb_data;
         end
         busy_q <= busy_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            op1_q       <= rs1_val;
            op2_q       <= uses_rs2 ? rs2_val : '0;
            opcode_q    <= dec_opcode;
            imm_q       <= is_itype ? bus_io.instr[9:0] : 10'd0;
            rd_q        <= dec_rd;
            illegal_q   <= (dec_opcode > 5'b10011);
         end else if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.op1       = op1_q;
   assign bus_io.op2       = op2_q;
   assign bus_io.opcode    = opcode_q;
   assign bus_io.immediate = imm_q;
   assign bus_io.rd        = rd_q;
   assign bus_io.illegal   = illegal_q;

endmodule
